// File: rtl/uart_alu_sequencer_if.sv
// rtl/uart_alu_sequencer_if.sv - receiver/ALU/transmitter handshake bundle for the sequencer
interface uart_alu_sequencer_if #(
  parameter int N_DATA       = 8,
  parameter int PARITY_CHECK = 1,
  parameter int NB_OPERATION = 6
);
  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data;
  logic                           i_rx_done;
  logic [N_DATA-1:0]              i_alu_data;
  logic                           i_tx_done;
  logic [N_DATA-1:0]              o_alu_data_a;
  logic [N_DATA-1:0]              o_alu_data_b;
  logic [NB_OPERATION-1:0]        o_alu_data_op;
  logic [N_DATA-1:0]              o_tx_data;
  logic                           o_tx_start;
  logic                           o_busy;
  logic                           o_err;
  logic [7:0]                     o_err_count;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_data, i_tx_done,
    output o_alu_data_a, o_alu_data_b, o_alu_data_op, o_tx_data,
    output o_tx_start, o_busy, o_err, o_err_count
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_data, i_tx_done,
    input  o_alu_data_a, o_alu_data_b, o_alu_data_op, o_tx_data,
    input  o_tx_start, o_busy, o_err, o_err_count
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A, B, opcode bytes from a UART receiver, runs the ALU, sends the result
module uart_alu_sequencer #(
  parameter int N_DATA         = 8,
  parameter int PARITY_CHECK   = 1,
  parameter int NB_OPERATION   = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                  i_clk,
  input logic                  i_rst,
  uart_alu_sequencer_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;

  state_t                  state;
  logic [TW-1:0]           tcnt;
  logic [N_DATA-1:0]       a_q, b_q, tx_q;
  logic [NB_OPERATION-1:0] op_q;
  logic                    start_q, busy_q, err_q;
  logic [7:0]              err_cnt;
  logic                    parity_ok, counting, timeout_hit, rx_good, err_event;

  generate
    if (PARITY_CHECK != 0) begin : g_par
      assign parity_ok = ~^bus.i_rx_data;
    end else begin : g_nopar
      assign parity_ok = 1'b1;
    end
  endgenerate

  // Bad parity and overrun both land in the first term; a good byte or tx_done beats a timeout.
  always_comb begin
    counting    = (state == WAIT_B) || (state == WAIT_OP) || (state == WAIT_TX);
    timeout_hit = counting && (tcnt == T_LAST);
    rx_good     = bus.i_rx_done && parity_ok &&
                  ((state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP));
    err_event   = 1'b0;
    if (bus.i_rx_done && !rx_good) err_event = 1'b1;
    if (timeout_hit && !rx_good && !((state == WAIT_TX) && bus.i_tx_done)) err_event = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= WAIT_A;
      tcnt    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      start_q <= 1'b0;
      err_q   <= err_event;
      if (err_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      case (state)
        WAIT_A, WAIT_B, WAIT_OP: begin
          if (bus.i_rx_done && !parity_ok) begin
            state <= WAIT_A;
            tcnt  <= '0;
          end else if (rx_good) begin
            tcnt <= '0;
            if (state == WAIT_A) begin
              a_q   <= bus.i_rx_data[N_DATA-1:0];
              state <= WAIT_B;
            end else if (state == WAIT_B) begin
              b_q   <= bus.i_rx_data[N_DATA-1:0];
              state <= WAIT_OP;
            end else begin
              op_q   <= bus.i_rx_data[NB_OPERATION-1:0];
              state  <= EXEC;
              busy_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            state <= WAIT_A;
            tcnt  <= '0;
          end else if (counting) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        EXEC: begin
          tx_q  <= bus.i_alu_data;
          state <= SEND;
          tcnt  <= '0;
        end
        SEND: begin
          start_q <= 1'b1;
          state   <= WAIT_TX;
          tcnt    <= '0;
        end
        WAIT_TX: begin
          if (bus.i_tx_done || timeout_hit) begin
            state  <= WAIT_A;
            busy_q <= 1'b0;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state  <= WAIT_A;
          busy_q <= 1'b0;
          tcnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_alu_data_a  = a_q;
  assign bus.o_alu_data_b  = b_q;
  assign bus.o_alu_data_op = op_q;
  assign bus.o_tx_data     = tx_q;
  assign bus.o_tx_start    = start_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err         = err_q;
  assign bus.o_err_count   = err_cnt;
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - directed self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_alu_sequencer_if #(.N_DATA(8), .PARITY_CHECK(1), .NB_OPERATION(6)) bus ();

  uart_alu_sequencer #(
    .N_DATA(8), .PARITY_CHECK(1), .NB_OPERATION(6), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  // ALU stand-in: opcode 0x20 adds, anything else subtracts
  always_comb
    bus.i_alu_data = (bus.o_alu_data_op == 6'h20) ? bus.o_alu_data_a + bus.o_alu_data_b
                                                  : bus.o_alu_data_a - bus.o_alu_data_b;

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    bus.i_rx_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad);
    @(negedge clk);
    bus.i_rx_data = {(^d) ^ bad, d};
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_alu_data_a !== 8'h00) begin failures++; $display("FAIL reset_a got=%0h exp=00", bus.o_alu_data_a); end
    checks++; if (bus.o_alu_data_op !== 6'h00) begin failures++; $display("FAIL reset_op got=%0h exp=00", bus.o_alu_data_op); end
    checks++; if (bus.o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=00", bus.o_tx_data); end
    checks++; if ({bus.o_tx_start, bus.o_busy, bus.o_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.o_tx_start, bus.o_busy, bus.o_err}); end
    checks++; if (bus.o_err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", bus.o_err_count); end
  endtask

  task automatic test_basic();
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    checks++; if (bus.o_alu_data_a !== 8'h05) begin failures++; $display("FAIL basic_a got=%0h exp=05", bus.o_alu_data_a); end
    checks++; if (bus.o_alu_data_b !== 8'h03) begin failures++; $display("FAIL basic_b got=%0h exp=03", bus.o_alu_data_b); end
    checks++; if (bus.o_alu_data_op !== 6'h20) begin failures++; $display("FAIL basic_op got=%0h exp=20", bus.o_alu_data_op); end
    checks++; if ({bus.o_busy, bus.o_tx_start} !== 2'b10) begin failures++; $display("FAIL basic_exec_flags got=%b exp=10", {bus.o_busy, bus.o_tx_start}); end
    @(negedge clk);
    checks++; if (bus.o_tx_data !== 8'h08) begin failures++; $display("FAIL basic_tx_data got=%0h exp=08", bus.o_tx_data); end
    checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL basic_start_early got=%b exp=0", bus.o_tx_start); end
    @(negedge clk);
    checks++; if (bus.o_tx_start !== 1'b1) begin failures++; $display("FAIL basic_start got=%b exp=1", bus.o_tx_start); end
    @(negedge clk);
    checks++; if ({bus.o_tx_start, bus.o_busy} !== 2'b01) begin failures++; $display("FAIL basic_start_single got=%b exp=01", {bus.o_tx_start, bus.o_busy}); end
    pulse_tx_done();
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_parity_error();
    int starts;
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b1);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL parity_err got=%b exp=1", bus.o_err); end
    checks++; if (bus.o_err_count !== 8'd1) begin failures++; $display("FAIL parity_count got=%0d exp=1", bus.o_err_count); end
    checks++; if (bus.o_alu_data_b !== 8'h00) begin failures++; $display("FAIL parity_b_kept got=%0h exp=00", bus.o_alu_data_b); end
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin failures++; $display("FAIL parity_err_width got=%b exp=0", bus.o_err); end
    send_byte(8'h07, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    starts = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_tx_start) starts++;
    end
    checks++; if (bus.o_alu_data_a !== 8'h07) begin failures++; $display("FAIL parity_restart_a got=%0h exp=07", bus.o_alu_data_a); end
    checks++; if (bus.o_tx_data !== 8'h09) begin failures++; $display("FAIL parity_restart_tx got=%0h exp=09", bus.o_tx_data); end
    checks++; if (starts !== 1) begin failures++; $display("FAIL parity_restart_starts got=%0d exp=1", starts); end
    pulse_tx_done();
  endtask

  task automatic test_timeout();
    int first_err, starts;
    do_reset();
    send_byte(8'h05, 1'b0);
    first_err = 0;
    starts = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.o_err && first_err == 0) first_err = k;
      if (bus.o_tx_start) starts++;
    end
    checks++; if (first_err !== 16) begin failures++; $display("FAIL timeout_cycle got=%0d exp=16", first_err); end
    checks++; if (starts !== 0) begin failures++; $display("FAIL timeout_no_start got=%0d exp=0", starts); end
    checks++; if (bus.o_err_count !== 8'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", bus.o_err_count); end
    send_byte(8'h33, 1'b0);
    checks++; if (bus.o_alu_data_a !== 8'h33) begin failures++; $display("FAIL timeout_back_to_a got=%0h exp=33", bus.o_alu_data_a); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    send_byte(8'h55, 1'b0);
    checks++; if (bus.o_err !== 1'b1) begin failures++; $display("FAIL overrun_err got=%b exp=1", bus.o_err); end
    checks++; if (bus.o_tx_data !== 8'h08) begin failures++; $display("FAIL overrun_tx_data got=%0h exp=08", bus.o_tx_data); end
    checks++; if (bus.o_alu_data_a !== 8'h05) begin failures++; $display("FAIL overrun_a got=%0h exp=05", bus.o_alu_data_a); end
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL overrun_still_waiting got=%b exp=1", bus.o_busy); end
    pulse_tx_done();
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL overrun_done got=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_reset_mid();
    int starts;
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h03, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.o_alu_data_a, bus.o_alu_data_b} !== 16'h0000) begin failures++; $display("FAIL midrst_ab got=%0h exp=0000", {bus.o_alu_data_a, bus.o_alu_data_b}); end
    checks++; if (bus.o_err_count !== 8'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.o_err_count); end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h20, 1'b0);
    starts = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_tx_start) starts++;
    end
    checks++; if (bus.o_alu_data_a !== 8'h20) begin failures++; $display("FAIL midrst_first_is_a got=%0h exp=20", bus.o_alu_data_a); end
    checks++; if (starts !== 0) begin failures++; $display("FAIL midrst_no_start got=%0d exp=0", starts); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 300; k++) send_byte(8'h5A, 1'b1);
    checks++; if (bus.o_err_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", bus.o_err_count); end
    checks++; if (bus.o_alu_data_a !== 8'h00) begin failures++; $display("FAIL sat_a_kept got=%0h exp=00", bus.o_alu_data_a); end
  endtask

  initial begin
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    test_reset();
    test_basic();
    test_parity_error();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Parameters
REQ-001 The block SHALL have parameter N_DATA, default 8, giving the data byte width.
REQ-002 The block SHALL have parameter PARITY_CHECK, default 1; when 1, bit N_DATA of i_rx_data is an even-parity bit over data plus parity.
REQ-003 The block SHALL have parameter NB_OPERATION, default 6, giving the opcode width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the inter-byte and TX-wait timeout in clocks.

Interface (name  direction  width  meaning)
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port i_rx_data, input, N_DATA+PARITY_CHECK bits: the received UART word.
REQ-008 The block SHALL have port i_rx_done, input, 1 bit: a one-cycle pulse marking i_rx_data valid.
REQ-009 The block SHALL have port i_alu_data, input, N_DATA bits: the combinational ALU result.
REQ-010 The block SHALL have port i_tx_done, input, 1 bit: a one-cycle pulse marking transmitter completion.
REQ-011 The block SHALL have ports o_alu_data_a and o_alu_data_b, outputs, N_DATA bits each: the registered operands.
REQ-012 The block SHALL have port o_alu_data_op, output, NB_OPERATION bits: the registered opcode.
REQ-013 The block SHALL have port o_tx_data, output, N_DATA bits: the result byte held for the transmitter.
REQ-014 The block SHALL have port o_tx_start, output, 1 bit: a one-cycle transmit request.
REQ-015 The block SHALL have port o_busy, output, 1 bit: high in states EXEC, SEND and WAIT_TX.
REQ-016 The block SHALL have port o_err, output, 1 bit: a one-cycle error pulse.
REQ-017 The block SHALL have port o_err_count, output, 8 bits: a saturating error counter.

Function
REQ-018 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-019 In WAIT_A, WAIT_B or WAIT_OP, an i_rx_done with good parity SHALL capture the word into a, b or op (op = low NB_OPERATION bits) on that edge and advance one state.
REQ-020 EXEC SHALL last exactly one cycle, load o_tx_data from i_alu_data and go to SEND.
REQ-021 SEND SHALL assert o_tx_start for exactly one cycle and go to WAIT_TX.
REQ-022 WAIT_TX SHALL return to WAIT_A on i_tx_done.
REQ-023 Latency SHALL be fixed: op-byte rx_done at edge t gives o_tx_data valid after edge t+1 and o_tx_start high during cycle t+2.
REQ-024 A parity mismatch (PARITY_CHECK=1) in any WAIT_A/B/OP state SHALL discard the word, pulse o_err and go to WAIT_A, leaving a, b and op unchanged.
REQ-025 With PARITY_CHECK=0, no parity check SHALL be performed.
REQ-026 The timeout counter SHALL clear on every state change and on every accepted rx_done.
REQ-027 The timeout counter SHALL count in WAIT_B, WAIT_OP and WAIT_TX; on reaching TIMEOUT_CYCLES it SHALL pulse o_err and go to WAIT_A.
REQ-028 WAIT_A SHALL never time out.
REQ-029 An i_rx_done while in EXEC, SEND or WAIT_TX SHALL drop the byte, pulse o_err and leave the state unchanged (overrun).
REQ-030 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-031 Simultaneous error events in one cycle SHALL produce one o_err pulse and one count increment.
REQ-032 When a timeout and a good rx_done coincide, the rx_done SHALL win.
REQ-033 o_err_count SHALL increment per o_err pulse and saturate at 255.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On assertion of i_rst, the block SHALL immediately, without a clock, set state WAIT_A, a/b/op/o_tx_data/timeout/o_err_count to 0, and o_tx_start/o_busy/o_err to 0.
REQ-036 A reset mid-sequence, including in WAIT_TX, SHALL abandon the transaction with no o_tx_start afterwards.
REQ-037 The first rx_done after reset release SHALL be taken as operand A.

Verification
REQ-038 Bench SHALL cover: bytes 0x05, 0x03, 0x20 with good parity and ALU model returning 0x08 -> a=0x05, b=0x03, op=0x20, o_tx_data=0x08, single o_tx_start two cycles after the third rx_done; after i_tx_done, o_busy=0.
REQ-039 Bench SHALL cover: A=0x05, then B=0x03 with the parity bit flipped -> o_err pulse, err_count=1, FSM back in WAIT_A; the next three good bytes complete normally.
REQ-040 Bench SHALL cover: A only, then silence for TIMEOUT_CYCLES (set to 16) -> o_err on cycle 16, state WAIT_A, no o_tx_start.
REQ-041 Bench SHALL cover: rx_done during WAIT_TX -> o_err, o_tx_data unchanged, still waiting for i_tx_done.
REQ-042 Bench SHALL cover: i_rst asserted between edges during WAIT_OP -> outputs zero before the next edge, no transmit.
REQ-043 Bench SHALL cover: 300 parity errors -> o_err_count=255.
